if_stage_sramlike: RTL and testbench

Parametrised instruction-fetch stage for the 5-stage LoongArch pipeline. It drives a handshaked SRAM-like instruction bus (`addr_ok`/`data_ok`), so memory latency can vary. Fetched instructions are held in a small in-order buffer, and in-flight fetches can be cancelled on exception, ertn or branch redirect. It sits between the instruction bus and the decode stage.

---
 rtl/if_stage_sramlike_if.sv | 15 +
 rtl/if_stage_sramlike.sv | 104 ++++++++++
 tb/tb_if_stage_sramlike.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/if_stage_sramlike_if.sv
// if_stage_sramlike_if: SRAM-like instruction bus between the fetch stage (master) and memory (slave).
interface if_stage_sramlike_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    modport master (output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
                    input  inst_addr_ok, inst_data_ok, inst_rdata);
    modport slave  (input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
                    output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/if_stage_sramlike.sv
// if_stage_sramlike: instruction fetch over an SRAM-like bus with one request in flight,
// an in-order instruction buffer, and cancellation of in-flight fetches on redirect.
module if_stage_sramlike #(
    parameter logic [31:0] RESET_PC   = 32'h1C00_0000,
    parameter int          IBUF_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    if_stage_sramlike_if.master         bus,
    input  logic                        ds_allowin,
    input  logic                        br_taken,
    input  logic [31:0]                 br_target,
    input  logic                        wb_ex,
    input  logic [31:0]                 ex_entry,
    input  logic                        ertn_flush,
    input  logic [31:0]                 ertn_entry,
    output logic                        fs2ds_valid,
    output logic [31:0]                 fs2ds_pc,
    output logic [31:0]                 fs2ds_inst,
    output logic                        fs2ds_adef
);
    localparam int PW = $clog2(IBUF_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } ent_t;

    ent_t [IBUF_DEPTH-1:0] ibuf_q, ibuf_d;
    logic          resetn_q;
    logic          out_valid_q, out_valid_d;
    logic          cancel_q, cancel_d;
    logic          adef_q, adef_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          redirect, can_issue, req, accept, resp, push, pop, adef_push;
    logic [31:0]   target;
    ent_t          push_ent;

    assign bus.inst_req   = req;
    assign bus.inst_wr    = 1'b0;
    assign bus.inst_size  = 2'b10;
    assign bus.inst_addr  = req_pc_q;
    assign bus.inst_wdata = 32'h0;
    assign fs2ds_pc       = ibuf_q[head_q].pc;
    assign fs2ds_inst     = ibuf_q[head_q].inst;
    assign fs2ds_adef     = ibuf_q[head_q].adef;

    always_comb begin
        redirect    = wb_ex | ertn_flush | br_taken;
        target      = wb_ex ? ex_entry : ertn_flush ? ertn_entry : br_target;
        can_issue   = resetn_q & ~out_valid_q & ~cancel_q & ~redirect &
                      (count_q < (PW+1)'(IBUF_DEPTH));
        req         = can_issue & (req_pc_q[1:0] == 2'b00);
        // adef_q limits a misaligned req_pc to a single fault entry until the next redirect
        adef_push   = can_issue & (req_pc_q[1:0] != 2'b00) & ~adef_q;
        accept      = req & bus.inst_addr_ok;
        resp        = bus.inst_data_ok & out_valid_q;
        push        = (resp & ~cancel_q & ~redirect) | adef_push;
        push_ent    = adef_push ? {req_pc_q, 32'h0, 1'b1} : {out_pc_q, bus.inst_rdata, 1'b0};
        fs2ds_valid = count_q != '0;
        pop         = fs2ds_valid & ds_allowin & ~redirect;
        out_valid_d = accept ? 1'b1 : resp ? 1'b0 : out_valid_q;
        out_pc_d    = accept ? req_pc_q : out_pc_q;
        // a response arriving with the redirect consumes the request, so nothing is left to cancel
        cancel_d    = resp ? 1'b0 : cancel_q | (redirect & out_valid_q);
        adef_d      = redirect ? 1'b0 : adef_q | adef_push;
        req_pc_d    = redirect ? target : accept ? req_pc_q + 32'd4 : req_pc_q;
        tail_d      = tail_q + PW'(push);
        head_d      = redirect ? tail_q : head_q + PW'(pop);
        count_d     = redirect ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
        ibuf_d      = ibuf_q;
        if (push) ibuf_d[tail_q] = push_ent;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            resetn_q    <= 1'b0;
            out_valid_q <= 1'b0;
            cancel_q    <= 1'b0;
            adef_q      <= 1'b0;
            req_pc_q    <= RESET_PC;
            out_pc_q    <= 32'h0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ibuf_q      <= '0;
        end else begin
            resetn_q    <= 1'b1;
            out_valid_q <= out_valid_d;
            cancel_q    <= cancel_d;
            adef_q      <= adef_d;
            req_pc_q    <= req_pc_d;
            out_pc_q    <= out_pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ibuf_q      <= ibuf_d;
        end
    end
endmodule

// File: tb/tb_if_stage_sramlike.sv
// tb_if_stage_sramlike: random bus latency, backpressure and redirects; the expected
// decode stream is rebuilt from each redirect target and compared on every pop.
module tb_if_stage_sramlike;
    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } exp_t;

    logic        clk = 1'b0, resetn = 1'b0, ds_allowin = 1'b0;
    logic        br_taken = 1'b0, wb_ex = 1'b0, ertn_flush = 1'b0;
    logic [31:0] br_target = '0, ex_entry = '0, ertn_entry = '0;
    logic        fs2ds_valid, fs2ds_adef;
    logic [31:0] fs2ds_pc, fs2ds_inst;
    int          total = 0, bad = 0, n_acc = 0, n_pop = 0;
    bit          fast = 1'b1;
    exp_t        exp_q[$];

    if_stage_sramlike_if bus();

    if_stage_sramlike #(.RESET_PC(RST_PC), .IBUF_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .bus(bus), .ds_allowin(ds_allowin),
        .br_taken(br_taken), .br_target(br_target), .wb_ex(wb_ex), .ex_entry(ex_entry),
        .ertn_flush(ertn_flush), .ertn_entry(ertn_entry), .fs2ds_valid(fs2ds_valid),
        .fs2ds_pc(fs2ds_pc), .fs2ds_inst(fs2ds_inst), .fs2ds_adef(fs2ds_adef)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        t = RST_PC + 32'($urandom_range(0, 1023)) * 32'd4;
        if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Decode must see target, target+4, ... or a single fault entry for a misaligned target.
    task automatic new_stream(input logic [31:0] t);
        exp_q.delete();
        if (t[1:0] != 2'b00) exp_q.push_back('{t, 32'h0, 1'b1});
        else for (int i = 0; i < 300; i++) exp_q.push_back('{t + 32'(4*i), mem(t + 32'(4*i)), 1'b0});
    endtask

    initial begin
        bit          pend = 1'b0;
        int          lat = 0;
        logic [31:0] pa = '0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.inst_data_ok = 1'b0;
            bus.inst_rdata   = $urandom;
            if (!resetn) begin
                pend = 1'b0;
                bus.inst_addr_ok = 1'b0;
                continue;
            end
            if (pend) begin
                if (lat == 0) begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata   = mem(pa);
                    pend = 1'b0;
                end else lat--;
            end else if ($urandom_range(0, 7) == 0) bus.inst_data_ok = 1'b1;
            bus.inst_addr_ok = fast ? 1'b1 : ($urandom_range(0, 9) < 6);
            if (bus.inst_req && bus.inst_addr_ok) begin
                pend = 1'b1;
                pa   = bus.inst_addr;
                lat  = fast ? 0 : int'($urandom_range(0, 3));
            end
        end
    end

    initial begin
        bit          hold = 1'b0;
        logic [31:0] ha = '0;
        logic        redir;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (!resetn) begin
                hold = 1'b0;
                continue;
            end
            redir = wb_ex | ertn_flush | br_taken;
            if (bus.inst_req) chk("req_aligned", 32'(bus.inst_addr[1:0]), 32'h0);
            if (hold && !redir) begin
                chk("hold_req", 32'(bus.inst_req), 32'h1);
                chk("hold_addr", bus.inst_addr, ha);
            end
            hold = bus.inst_req & ~bus.inst_addr_ok;
            ha   = bus.inst_addr;
            if (bus.inst_req && bus.inst_addr_ok) n_acc++;
            if (fs2ds_valid && ds_allowin && !redir) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_extra: got pc %h want no entry", fs2ds_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", fs2ds_pc, e.pc);
                    chk("pop_inst", fs2ds_inst, e.inst);
                    chk("pop_adef", 32'(fs2ds_adef), 32'(e.adef));
                end
            end
        end
    end

    initial begin
        logic [31:0] t;
        int          a;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_req", 32'(bus.inst_req), 32'h0);
        chk("rst_addr", bus.inst_addr, RST_PC);
        chk("rst_valid", 32'(fs2ds_valid), 32'h0);
        chk("rst_pc", fs2ds_pc, 32'h0);
        chk("rst_inst", fs2ds_inst, 32'h0);
        chk("rst_adef", 32'(fs2ds_adef), 32'h0);
        chk("const_wr", 32'(bus.inst_wr), 32'h0);
        chk("const_size", 32'(bus.inst_size), 32'h2);
        chk("const_wdata", bus.inst_wdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        new_stream(RST_PC);
        repeat (30) @(negedge clk);
        #3;
        chk("bp_accepts", 32'(n_acc), 32'd4);
        chk("bp_req", 32'(bus.inst_req), 32'h0);
        chk("bp_valid", 32'(fs2ds_valid), 32'h1);
        chk("bp_head_pc", fs2ds_pc, RST_PC);
        fast = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ds_allowin = $urandom_range(0, 3) != 0;
            {wb_ex, ertn_flush, br_taken} = 3'b000;
            if ($urandom_range(0, 24) == 0) begin
                {wb_ex, ertn_flush, br_taken} = 3'($urandom_range(1, 7));
                ex_entry   = rnd_tgt();
                ertn_entry = rnd_tgt();
                br_target  = rnd_tgt();
                new_stream(wb_ex ? ex_entry : ertn_flush ? ertn_entry : br_target);
            end
        end
        @(negedge clk);
        {wb_ex, ertn_flush} = 2'b00;
        fast       = 1'b1;
        ds_allowin = 1'b1;
        br_taken   = 1'b1;
        br_target  = 32'h1C00_0102;
        new_stream(br_target);
        @(negedge clk);
        br_taken = 1'b0;
        a = n_acc;
        repeat (12) @(negedge clk);
        #3;
        chk("adef_no_req", 32'(n_acc), 32'(a));
        chk("adef_popped", 32'(exp_q.size()), 32'h0);
        @(negedge clk);
        ertn_flush = 1'b1;
        ertn_entry = 32'h1C00_0200;
        new_stream(ertn_entry);
        @(negedge clk);
        ertn_flush = 1'b0;
        repeat (30) @(negedge clk);
        #3;
        chk("ertn_progress", 32'(exp_q.size() < 300), 32'h1);
        chk("pop_progress", 32'(n_pop > 200), 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
